// File: rtl/iob_native_bridge_pkg.sv
// Shared types and helpers for the native-to-IOb bridge: FSM state encoding and
// timeout counter sizing.
package iob_native_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_SEL_W   = 1;
    localparam int unsigned DEF_N_CH    = 3;
    localparam int unsigned DEF_TIMEOUT = 255;

    // Counter only needs to reach TIMEOUT-1; keep at least one bit so the
    // disabled (TIMEOUT=0) build still elaborates cleanly.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/iob_native_bridge_if.sv
// Bus bundle for the bridge: native CPU request/response plus N_CH flattened IOb channels.
// 'slave' is the bridge's view, 'master' is the CPU/interconnect side driving it.
interface iob_native_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_CH   = 3
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic                     nat_valid;
    logic                     nat_instr;
    logic [ADDR_W-1:0]        nat_addr;
    logic [DATA_W-1:0]        nat_wdata;
    logic [STRB_W-1:0]        nat_wstrb;
    logic                     nat_ready;
    logic [DATA_W-1:0]        nat_rdata;
    logic                     nat_err;

    logic [N_CH-1:0]          iob_avalid;
    logic [N_CH*ADDR_W-1:0]   iob_addr;
    logic [N_CH*DATA_W-1:0]   iob_wdata;
    logic [N_CH*STRB_W-1:0]   iob_wstrb;
    logic [N_CH*DATA_W-1:0]   iob_rdata;
    logic [N_CH-1:0]          iob_rvalid;
    logic [N_CH-1:0]          iob_ready;

    modport slave (
        input  nat_valid, nat_instr, nat_addr, nat_wdata, nat_wstrb,
        output nat_ready, nat_rdata, nat_err,
        output iob_avalid, iob_addr, iob_wdata, iob_wstrb,
        input  iob_rdata, iob_rvalid, iob_ready
    );

    modport master (
        output nat_valid, nat_instr, nat_addr, nat_wdata, nat_wstrb,
        input  nat_ready, nat_rdata, nat_err,
        input  iob_avalid, iob_addr, iob_wdata, iob_wstrb,
        output iob_rdata, iob_rvalid, iob_ready
    );

endinterface

// File: rtl/iob_native_bridge_tmr.sv
// Per-access timeout counter: cleared while idle, counts while an access is pending,
// flags expiry on the cycle it reaches TIMEOUT-1 so the FSM leaves on the next edge.
module iob_native_bridge_tmr
    import iob_native_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic cke,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CNT_W = cnt_width(TIMEOUT);
    localparam int unsigned LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    logic [CNT_W-1:0] cnt_q;

    assign expired = (TIMEOUT != 0) && en && (cnt_q == CNT_W'(LIMIT));

    // NOTE: sequential state uses non-blocking assignments and a synchronous
    // reset tested first; cke gates every update so a stalled clock domain holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cke) begin
            if (clr) begin
                cnt_q <= '0;
            end else if (en && !expired) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_native_bridge.sv
// Bridge from a PicoRV32-style native memory port to N_CH IOb channels: one access
// in flight, instruction fetches on channel 0, data on 1+addr[MSB field], timeout error.
module iob_native_bridge
    import iob_native_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned SEL_W   = DEF_SEL_W,
    parameter int unsigned N_CH    = DEF_N_CH,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,
    iob_native_bridge_if.slave  bus
);
    localparam int unsigned STRB_W = DATA_W / 8;
    // One extra bit so 1 + sel (up to 2**SEL_W) and N_CH both fit.
    localparam int unsigned IDX_W  = SEL_W + 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q,   err_d;

    logic [IDX_W-1:0]    req_idx;
    logic                req_unmapped;
    logic                is_write;
    logic                sel_ready;
    logic                sel_rvalid;
    logic [DATA_W-1:0]   sel_rdata;
    logic                tmr_clr;
    logic                tmr_en;
    logic                tmr_expired;

    logic [N_CH-1:0]        avalid_c;
    logic [N_CH*ADDR_W-1:0] addr_c;
    logic [N_CH*DATA_W-1:0] wdata_c;
    logic [N_CH*STRB_W-1:0] wstrb_c;

    assign req_idx      = bus.nat_instr ? '0
                        : {1'b0, bus.nat_addr[ADDR_W-1 -: SEL_W]} + IDX_W'(1);
    assign req_unmapped = (req_idx >= IDX_W'(N_CH));
    assign is_write     = |wstrb_q;

    // Response mux: only the captured channel's handshake is ever observed.
    always_comb begin
        sel_ready  = 1'b0;
        sel_rvalid = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ready  = bus.iob_ready[i];
                sel_rvalid = bus.iob_rvalid[i];
                sel_rdata  = bus.iob_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.nat_valid) begin
                    idx_d   = req_idx;
                    addr_d  = bus.nat_addr;
                    wdata_d = bus.nat_wdata;
                    wstrb_d = bus.nat_wstrb;
                    rdata_d = '0;
                    err_d   = req_unmapped;
                    state_d = req_unmapped ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                // An accepted request wins over expiry on the same cycle.
                if (sel_ready) begin
                    if (is_write) begin
                        state_d = ST_DONE;
                    end else if (sel_rvalid) begin
                        rdata_d = sel_rdata;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_RESP: begin
                if (sel_rvalid) begin
                    rdata_d = sel_rdata;
                    state_d = ST_DONE;
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign tmr_clr = (state_q == ST_IDLE);
    assign tmr_en  = (state_q == ST_REQ) || (state_q == ST_RESP);

    iob_native_bridge_tmr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmr (
        .clk     (clk_i),
        .rst     (rst_i),
        .cke     (cke_i),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Channel outputs are decoded from registered state, so only the selected
    // slice is non-zero and only while the request is being presented.
    always_comb begin
        avalid_c = '0;
        addr_c   = '0;
        wdata_c  = '0;
        wstrb_c  = '0;
        if (state_q == ST_REQ) begin
            for (int i = 0; i < N_CH; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    avalid_c[i]                   = 1'b1;
                    addr_c[i*ADDR_W +: ADDR_W]    = addr_q;
                    wdata_c[i*DATA_W +: DATA_W]   = wdata_q;
                    wstrb_c[i*STRB_W +: STRB_W]   = wstrb_q;
                end
            end
        end
    end

    assign bus.iob_avalid = avalid_c;
    assign bus.iob_addr   = addr_c;
    assign bus.iob_wdata  = wdata_c;
    assign bus.iob_wstrb  = wstrb_c;

    assign bus.nat_ready  = (state_q == ST_DONE);
    assign bus.nat_rdata  = (state_q == ST_DONE) ? rdata_q : '0;
    assign bus.nat_err    = (state_q == ST_DONE) ? err_q : 1'b0;

endmodule

// File: tb/tb_iob_native_bridge.sv
// Directed bench for iob_native_bridge: a 3-channel instance with TIMEOUT=4 and a
// 2-channel instance with timeout disabled, stepped cycle by cycle against fixed expectations.
module tb_iob_native_bridge;

    logic clk = 1'b0;
    logic rst;
    logic cke;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    iob_native_bridge_if #(.ADDR_W(32), .DATA_W(32), .N_CH(3)) bus0 ();
    iob_native_bridge_if #(.ADDR_W(32), .DATA_W(32), .N_CH(2)) bus1 ();

    iob_native_bridge #(
        .ADDR_W(32), .DATA_W(32), .SEL_W(1), .N_CH(3), .TIMEOUT(4)
    ) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .cke_i (cke),
        .bus   (bus0)
    );

    iob_native_bridge #(
        .ADDR_W(32), .DATA_W(32), .SEL_W(1), .N_CH(2), .TIMEOUT(0)
    ) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .cke_i (cke),
        .bus   (bus1)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus0.nat_valid  = 1'b0; bus0.nat_instr = 1'b0; bus0.nat_addr = '0;
        bus0.nat_wdata  = '0;   bus0.nat_wstrb = '0;
        bus0.iob_rdata  = '0;   bus0.iob_rvalid = '0;  bus0.iob_ready = '0;
        bus1.nat_valid  = 1'b0; bus1.nat_instr = 1'b0; bus1.nat_addr = '0;
        bus1.nat_wdata  = '0;   bus1.nat_wstrb = '0;
        bus1.iob_rdata  = '0;   bus1.iob_rvalid = '0;  bus1.iob_ready = '0;
    endtask

    initial begin
        rst = 1'b1;
        cke = 1'b1;
        clear_inputs();
        step();
        step();

        // Reset state
        check("rst_ready0",  bus0.nat_ready,  1'b0);
        check("rst_err0",    bus0.nat_err,    1'b0);
        check("rst_rdata0",  bus0.nat_rdata,  32'h0);
        check("rst_avalid0", bus0.iob_avalid, 3'b000);
        check("rst_addr0",   bus0.iob_addr,   96'h0);
        check("rst_avalid1", bus1.iob_avalid, 2'b00);
        rst = 1'b0;
        step();

        // 1: instruction read on ch0, ready@1, rvalid@2, nat_ready@3
        bus0.nat_valid = 1'b1; bus0.nat_instr = 1'b1; bus0.nat_addr = 32'h0000_0100;
        step();
        check("t1_avalid",  bus0.iob_avalid, 3'b001);
        check("t1_addr",    bus0.iob_addr,   {32'h0, 32'h0, 32'h0000_0100});
        check("t1_wstrb",   bus0.iob_wstrb,  12'h000);
        bus0.iob_ready = 3'b001;
        step();
        check("t1_resp_avalid", bus0.iob_avalid, 3'b000);
        check("t1_resp_ready",  bus0.nat_ready,  1'b0);
        bus0.iob_ready  = 3'b000;
        bus0.iob_rvalid = 3'b001;
        bus0.iob_rdata  = {32'h0, 32'h0, 32'hDEAD_BEEF};
        step();
        check("t1_ready", bus0.nat_ready, 1'b1);
        check("t1_rdata", bus0.nat_rdata, 32'hDEAD_BEEF);
        check("t1_err",   bus0.nat_err,   1'b0);
        clear_inputs();
        step();
        check("t1_pulse_end", bus0.nat_ready, 1'b0);
        check("t1_rdata_end", bus0.nat_rdata, 32'h0);

        // 2: data write, addr MSB=1 -> ch2 only; nat_ready one cycle after ready
        bus0.nat_valid = 1'b1; bus0.nat_instr = 1'b0; bus0.nat_addr = 32'h8000_0004;
        bus0.nat_wdata = 32'h1234_5678; bus0.nat_wstrb = 4'hF;
        step();
        check("t2_avalid", bus0.iob_avalid, 3'b100);
        check("t2_addr",   bus0.iob_addr,   {32'h8000_0004, 32'h0, 32'h0});
        check("t2_wdata",  bus0.iob_wdata,  {32'h1234_5678, 32'h0, 32'h0});
        check("t2_wstrb",  bus0.iob_wstrb,  12'hF00);
        bus0.iob_ready = 3'b110;
        step();
        check("t2_ready",  bus0.nat_ready, 1'b1);
        check("t2_err",    bus0.nat_err,   1'b0);
        check("t2_rdata",  bus0.nat_rdata, 32'h0);
        clear_inputs();
        step();
        check("t2_pulse_end", bus0.nat_ready, 1'b0);

        // 2b: data read, addr MSB=0 -> ch1; ready+rvalid together; ch0 noise ignored
        bus0.nat_valid = 1'b1; bus0.nat_addr = 32'h0000_0010;
        step();
        check("t2b_avalid", bus0.iob_avalid, 3'b010);
        bus0.iob_ready  = 3'b011;
        bus0.iob_rvalid = 3'b011;
        bus0.iob_rdata  = {32'h0, 32'hCAFE_0001, 32'h0000_0BAD};
        step();
        check("t2b_ready", bus0.nat_ready, 1'b1);
        check("t2b_rdata", bus0.nat_rdata, 32'hCAFE_0001);
        clear_inputs();
        step();

        // 3: N_CH=2, data addr 0x8000_0000 -> index 2 unmapped
        bus1.nat_valid = 1'b1; bus1.nat_addr = 32'h8000_0000;
        step();
        check("t3_ready",  bus1.nat_ready,  1'b1);
        check("t3_err",    bus1.nat_err,    1'b1);
        check("t3_rdata",  bus1.nat_rdata,  32'h0);
        check("t3_avalid", bus1.iob_avalid, 2'b00);
        clear_inputs();
        step();
        check("t3_pulse_end", bus1.nat_ready, 1'b0);

        // 4: TIMEOUT=4, slave silent -> avalid for 4 cycles, then error completion
        bus0.nat_valid = 1'b1; bus0.nat_instr = 1'b1; bus0.nat_addr = 32'h0000_0200;
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("t4_avalid_c%0d", c), bus0.iob_avalid, 3'b001);
            check($sformatf("t4_busy_c%0d", c),   bus0.nat_ready,  1'b0);
        end
        step();
        check("t4_ready",  bus0.nat_ready,  1'b1);
        check("t4_err",    bus0.nat_err,    1'b1);
        check("t4_rdata",  bus0.nat_rdata,  32'h0);
        check("t4_avalid", bus0.iob_avalid, 3'b000);
        bus0.nat_valid  = 1'b0;
        bus0.iob_ready  = 3'b001;
        bus0.iob_rvalid = 3'b001;
        bus0.iob_rdata  = {32'h0, 32'h0, 32'h0000_0055};
        step();
        check("t4_late_a", bus0.nat_ready, 1'b0);
        step();
        check("t4_late_b",   bus0.nat_ready,  1'b0);
        check("t4_late_av",  bus0.iob_avalid, 3'b000);
        clear_inputs();
        step();

        // 5: no-timeout instance, ready withheld 3 cycles, then ready+rvalid together
        bus1.nat_valid = 1'b1; bus1.nat_instr = 1'b1; bus1.nat_addr = 32'h0000_0040;
        for (int c = 1; c <= 3; c++) begin
            step();
            check($sformatf("t5_avalid_c%0d", c), bus1.iob_avalid, 2'b01);
            check($sformatf("t5_busy_c%0d", c),   bus1.nat_ready,  1'b0);
        end
        bus1.iob_ready  = 2'b01;
        bus1.iob_rvalid = 2'b01;
        bus1.iob_rdata  = {32'h0, 32'hA5A5_0F0F};
        step();
        check("t5_ready", bus1.nat_ready, 1'b1);
        check("t5_rdata", bus1.nat_rdata, 32'hA5A5_0F0F);
        check("t5_err",   bus1.nat_err,   1'b0);
        clear_inputs();
        step();
        check("t5_single_a", bus1.nat_ready, 1'b0);
        step();
        check("t5_single_b", bus1.nat_ready, 1'b0);

        // cke=0 for longer than TIMEOUT: state and counter frozen, access still completes
        bus0.nat_valid = 1'b1; bus0.nat_instr = 1'b1; bus0.nat_addr = 32'h0000_0080;
        step();
        check("cke_avalid_start", bus0.iob_avalid, 3'b001);
        cke = 1'b0;
        for (int c = 0; c < 6; c++) step();
        check("cke_avalid_held", bus0.iob_avalid, 3'b001);
        check("cke_no_timeout",  bus0.nat_ready,  1'b0);
        cke = 1'b1;
        bus0.iob_ready  = 3'b001;
        bus0.iob_rvalid = 3'b001;
        bus0.iob_rdata  = {32'h0, 32'h0, 32'h1122_3344};
        step();
        check("cke_ready", bus0.nat_ready, 1'b1);
        check("cke_err",   bus0.nat_err,   1'b0);
        check("cke_rdata", bus0.nat_rdata, 32'h1122_3344);
        clear_inputs();
        step();

        // 6: reset while in RESP -> back to IDLE, no pulse; next read is clean
        bus0.nat_valid = 1'b1; bus0.nat_instr = 1'b1; bus0.nat_addr = 32'h0000_0300;
        step();
        bus0.iob_ready = 3'b001;
        step();
        check("t6_resp_avalid", bus0.iob_avalid, 3'b000);
        bus0.iob_ready  = 3'b000;
        bus0.iob_rvalid = 3'b001;
        bus0.iob_rdata  = {32'h0, 32'h0, 32'h00BA_DBAD};
        rst = 1'b1;
        step();
        check("t6_rst_ready",  bus0.nat_ready,  1'b0);
        check("t6_rst_avalid", bus0.iob_avalid, 3'b000);
        rst = 1'b0;
        clear_inputs();
        step();
        check("t6_idle_ready", bus0.nat_ready, 1'b0);
        bus0.nat_valid = 1'b1; bus0.nat_instr = 1'b1; bus0.nat_addr = 32'h0000_0304;
        step();
        check("t6_new_avalid", bus0.iob_avalid, 3'b001);
        check("t6_new_addr",   bus0.iob_addr,   {32'h0, 32'h0, 32'h0000_0304});
        bus0.iob_ready  = 3'b001;
        bus0.iob_rvalid = 3'b001;
        bus0.iob_rdata  = {32'h0, 32'h0, 32'h600D_0001};
        step();
        check("t6_new_ready", bus0.nat_ready, 1'b1);
        check("t6_new_rdata", bus0.nat_rdata, 32'h600D_0001);
        check("t6_new_err",   bus0.nat_err,   1'b0);
        clear_inputs();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
